// File: rtl/ti_quiesce_unit.sv
// Quiesce controller: gates new requests, drains outstanding work, then acknowledges a stop.
// stop_ack follows stop_req by 2 edges when idle; requests stall (ready=0) outside RUN or at counter max.
module ti_quiesce_unit #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             sys_clk,
    input  logic             sys_reset,
    input  logic             stop_req,
    output logic             stop_ack,
    input  logic             s_req_valid,
    output logic             s_req_ready,
    output logic             m_req_valid,
    input  logic             m_req_ready,
    input  logic             rsp_done,
    output logic [CNT_W-1:0] outstanding,
    output logic             timeout_err
);

    localparam int               TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {RUN, DRAIN, STOPPED} state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic             ack_nxt, terr_nxt;
    logic             pass, accept, retire, drain_done;

    // Saturation gate keeps the counter from wrapping without needing an overflow path.
    assign pass        = (state == RUN) && (outstanding != CNT_MAX);
    assign m_req_valid = pass & s_req_valid;
    assign s_req_ready = pass & m_req_ready;
    assign accept      = m_req_valid & m_req_ready;
    assign retire      = rsp_done & (outstanding != '0);

    assign drain_done = (outstanding == '0) ||
                        (stop_req && (outstanding == CNT_ONE) && rsp_done);

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            outstanding <= '0;
        end else if (accept && !retire) begin
            outstanding <= outstanding + CNT_ONE;
        end else if (retire && !accept) begin
            outstanding <= outstanding - CNT_ONE;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state       <= RUN;
            timer       <= '0;
            stop_ack    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            stop_ack    <= ack_nxt;
            timeout_err <= terr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        ack_nxt   = stop_ack;
        terr_nxt  = timeout_err;
        case (state)
            RUN: begin
                if (stop_req) begin
                    state_nxt = DRAIN;
                    timer_nxt = '0;
                end
            end
            DRAIN: begin
                timer_nxt = timer + 1'b1;
                // A withdrawn request wins; completion outranks the timeout.
                if (!stop_req) begin
                    state_nxt = RUN;
                end else if (drain_done) begin
                    state_nxt = STOPPED;
                    ack_nxt   = 1'b1;
                end else if (timer == TMR_LAST) begin
                    state_nxt = STOPPED;
                    ack_nxt   = 1'b1;
                    terr_nxt  = 1'b1;
                end
            end
            STOPPED: begin
                if (!stop_req) begin
                    state_nxt = RUN;
                    ack_nxt   = 1'b0;
                    terr_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = RUN;
                ack_nxt   = 1'b0;
                terr_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ti_quiesce_unit.sv
// Directed bench for ti_quiesce_unit with CNT_W=4 (max 15) and TIMEOUT=16.
module tb_ti_quiesce_unit;

    logic       sys_clk = 1'b0;
    logic       sys_reset;
    logic       stop_req;
    logic       stop_ack;
    logic       s_req_valid;
    logic       s_req_ready;
    logic       m_req_valid;
    logic       m_req_ready;
    logic       rsp_done;
    logic [3:0] outstanding;
    logic       timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    ti_quiesce_unit #(.CNT_W(4), .TIMEOUT(16)) dut (
        .sys_clk     (sys_clk),
        .sys_reset   (sys_reset),
        .stop_req    (stop_req),
        .stop_ack    (stop_ack),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .m_req_valid (m_req_valid),
        .m_req_ready (m_req_ready),
        .rsp_done    (rsp_done),
        .outstanding (outstanding),
        .timeout_err (timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        sys_reset   = 1'b1;
        stop_req    = 1'b0;
        s_req_valid = 1'b1;
        m_req_ready = 1'b1;
        rsp_done    = 1'b0;
        #2;
        check("rst_ack", stop_ack, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_out", outstanding, 0);
        check("rst_mvalid", m_req_valid, 1);
        check("rst_sready", s_req_ready, 1);
        s_req_valid = 1'b0;
        tick();
        sys_reset = 1'b0;

        // Idle stop: ack two edges after stop_req, released one edge after it drops
        stop_req = 1'b1;
        tick();
        check("idle_ack_e1", stop_ack, 0);
        tick();
        check("idle_ack_e2", stop_ack, 1);
        check("idle_terr", timeout_err, 0);
        s_req_valid = 1'b1;
        #1;
        check("idle_gate_v", m_req_valid, 0);
        check("idle_gate_r", s_req_ready, 0);
        s_req_valid = 1'b0;
        stop_req    = 1'b0;
        tick();
        check("idle_release", stop_ack, 0);
        s_req_valid = 1'b1;
        #1;
        check("idle_pass", m_req_valid, 1);
        s_req_valid = 1'b0;

        // Drain: third accept coincides with stop_req rising and is still counted
        s_req_valid = 1'b1;
        tick();
        tick();
        stop_req = 1'b1;
        tick();
        check("drain_out3", outstanding, 3);
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                check("drain_gate", m_req_valid, 0);
                check("drain_ack_lo", stop_ack, 0);
            end
            rsp_done = 1'b1;
            tick();
            rsp_done = 1'b0;
        end
        check("drain_ack", stop_ack, 1);
        check("drain_terr", timeout_err, 0);
        check("drain_out0", outstanding, 0);
        s_req_valid = 1'b0;
        stop_req    = 1'b0;
        tick();
        check("drain_release", stop_ack, 0);

        // Simultaneous accept + retire, then saturation at 15
        s_req_valid = 1'b1;
        repeat (5) tick();
        check("sim_out5", outstanding, 5);
        rsp_done = 1'b1;
        tick();
        check("sim_hold5", outstanding, 5);
        rsp_done = 1'b0;
        repeat (10) tick();
        check("sat_out15", outstanding, 15);
        check("sat_sready", s_req_ready, 0);
        check("sat_mvalid", m_req_valid, 0);
        tick();
        check("sat_hold15", outstanding, 15);
        s_req_valid = 1'b0;
        rsp_done    = 1'b1;
        repeat (15) tick();
        check("dec_out0", outstanding, 0);
        tick();
        check("no_underflow", outstanding, 0);
        rsp_done = 1'b0;

        // Timeout with 2 outstanding: ack exactly 16 edges after DRAIN entry
        s_req_valid = 1'b1;
        tick();
        tick();
        s_req_valid = 1'b0;
        stop_req    = 1'b1;
        tick();
        repeat (15) tick();
        check("to_ack_e15", stop_ack, 0);
        tick();
        check("to_ack_e16", stop_ack, 1);
        check("to_terr", timeout_err, 1);
        check("to_out2", outstanding, 2);
        rsp_done = 1'b1;
        tick();
        rsp_done = 1'b0;
        check("stopped_count", outstanding, 1);
        stop_req = 1'b0;
        tick();
        check("to_rel_ack", stop_ack, 0);
        check("to_rel_terr", timeout_err, 0);
        check("to_rel_out", outstanding, 1);

        // Abort: stop_req withdrawn mid-drain with 1 outstanding
        stop_req = 1'b1;
        tick();
        tick();
        check("abort_ack_a", stop_ack, 0);
        stop_req = 1'b0;
        tick();
        check("abort_ack_b", stop_ack, 0);
        s_req_valid = 1'b1;
        #1;
        check("abort_pass", m_req_valid, 1);
        s_req_valid = 1'b0;

        // Completion and timeout in the same cycle: completion wins
        stop_req = 1'b1;
        tick();
        repeat (15) tick();
        check("prio_ack_lo", stop_ack, 0);
        rsp_done = 1'b1;
        tick();
        rsp_done = 1'b0;
        check("prio_ack", stop_ack, 1);
        check("prio_terr", timeout_err, 0);
        check("prio_out", outstanding, 0);
        stop_req = 1'b0;
        tick();

        // Timeout again, then asynchronous reset while STOPPED with timeout_err set
        s_req_valid = 1'b1;
        tick();
        tick();
        s_req_valid = 1'b0;
        stop_req    = 1'b1;
        tick();
        repeat (16) tick();
        check("to2_terr", timeout_err, 1);
        sys_reset   = 1'b1;
        s_req_valid = 1'b1;
        #2;
        check("arst_ack", stop_ack, 0);
        check("arst_terr", timeout_err, 0);
        check("arst_out", outstanding, 0);
        check("arst_mvalid", m_req_valid, 1);
        check("arst_sready", s_req_ready, 1);
        s_req_valid = 1'b0;
        stop_req    = 1'b0;
        sys_reset   = 1'b0;
        tick();
        check("post_rst_ack", stop_ack, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
